// File: rtl/dram_cache_pkg.sv
// Shared types and address-field helpers for the DRAM cache memory-side responder.
package dram_cache_pkg;
  localparam int DC_ADDR_WIDTH   = 32;
  localparam int DC_DATA_WIDTH   = 512;
  localparam int DC_TAG_SIZE     = 16;
  localparam int DC_INDEX_WIDTH  = 10;
  localparam int DC_OFFSET_WIDTH = 6;

  typedef struct packed {
    logic [DC_TAG_SIZE-1:0]   tag;
    logic [DC_DATA_WIDTH-1:0] data;
  } line_t;

  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int unsigned lsb,
                                             input int unsigned width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int unsigned off_w,
                                             input int unsigned idx_w);
    return addr_field(addr, off_w, idx_w);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int unsigned off_w,
                                           input int unsigned idx_w, input int unsigned tag_w);
    return addr_field(addr, off_w + idx_w, tag_w);
  endfunction
endpackage

// File: rtl/mem_resp_queue.sv
// In-order read response FIFO; each entry counts down to its earliest R cycle.
module mem_resp_queue #(
  parameter int DEPTH  = 4,
  parameter int ID_W   = 4,
  parameter int LINE_W = 528,
  parameter int LAT    = 4,
  localparam int NW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ID_W-1:0]   push_id,
  input  logic [LINE_W-1:0] push_line,
  input  logic              pop,
  output logic [ID_W-1:0]   head_id,
  output logic [LINE_W-1:0] head_line,
  output logic              head_ok,
  output logic [NW-1:0]     count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LAT + 1);

  logic [PW-1:0]                  wr_ptr, rd_ptr;
  logic [DEPTH-1:0][ID_W-1:0]     id_q;
  logic [DEPTH-1:0][LINE_W-1:0]   line_q;
  logic [DEPTH-1:0][CW-1:0]       cd_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Loaded with LAT-1 so the head reaches zero exactly LAT cycles after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      id_q   <= '0;
      line_q <= '0;
      cd_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (cd_q[i] != '0) cd_q[i] <= cd_q[i] - CW'(1);
      if (push) begin
        id_q[wr_ptr]   <= push_id;
        line_q[wr_ptr] <= push_line;
        cd_q[wr_ptr]   <= CW'(LAT - 1);
        wr_ptr         <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + NW'(push) - NW'(pop);
    end
  end

  assign head_id   = id_q[rd_ptr];
  assign head_line = line_q[rd_ptr];
  assign head_ok   = (count != '0) && (cd_q[rd_ptr] == '0);
endmodule

// File: rtl/dram_cache_mem_resp.sv
// Memory-side responder for the DRAM cache m_* port: direct-mapped line store, AW/W fill, AR/R reads.
// Optional DRAM_CACHE_MEM_RESP_VALID_EN adds per-line valid bits; invalid lines read as a miss.
module dram_cache_mem_resp
  import dram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = DC_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DC_DATA_WIDTH,
  parameter int ID_WIDTH     = 4,
  parameter int TAG_SIZE     = DC_TAG_SIZE,
  parameter int INDEX_WIDTH  = DC_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DC_OFFSET_WIDTH,
  parameter int READ_LAT     = 4,
  parameter int RQ_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          arid_i,
  input  logic [ADDR_WIDTH-1:0]        araddr_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [ID_WIDTH-1:0]          rid_o,
  output logic [TAG_SIZE+DATA_WIDTH-1:0] rdata_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  input  logic [ID_WIDTH-1:0]          awid_i,
  input  logic [ADDR_WIDTH-1:0]        awaddr_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [ID_WIDTH-1:0]          wid_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic                         wvalid_i,
  output logic                         wready_o
);
  localparam int LINE_W = TAG_SIZE + DATA_WIDTH;
  localparam int LINES  = 2 ** INDEX_WIDTH;
  localparam int NW     = $clog2(RQ_DEPTH + 1);

  logic                   aw_full, w_full, commit;
  logic [ADDR_WIDTH-1:0]  aw_addr;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [INDEX_WIDTH-1:0] aw_idx, ar_idx;
  logic [TAG_SIZE-1:0]    aw_tag;
  logic [LINE_W-1:0]      rd_line;
  logic [LINE_W-1:0]      store [LINES];
  logic                   ar_fire;
  logic [NW-1:0]          q_count;

  logic unused_ids;
  assign unused_ids = ^{awid_i, wid_i};

  assign aw_idx = INDEX_WIDTH'(addr_index(64'(aw_addr), OFFSET_WIDTH, INDEX_WIDTH));
  assign aw_tag = TAG_SIZE'(addr_tag(64'(aw_addr), OFFSET_WIDTH, INDEX_WIDTH, TAG_SIZE));
  assign ar_idx = INDEX_WIDTH'(addr_index(64'(araddr_i), OFFSET_WIDTH, INDEX_WIDTH));

  assign commit    = aw_full && w_full;
  assign awready_o = !aw_full || commit;
  assign wready_o  = !w_full || commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
    end else begin
      if (awvalid_i && awready_o) begin
        aw_full <= 1'b1;
        aw_addr <= awaddr_i;
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (wvalid_i && wready_o) begin
        w_full <= 1'b1;
        w_data <= wdata_i;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  // Line contents are deliberately not reset; only the optional valid bits are.
  always_ff @(posedge clk)
    if (commit) store[aw_idx] <= {aw_tag, w_data};

`ifdef DRAM_CACHE_MEM_RESP_VALID_EN
  logic [LINES-1:0] line_vld;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_vld <= '0;
    else if (commit) line_vld[aw_idx] <= 1'b1;
  end
`endif

  // Write-first: a commit to the index being read this cycle is forwarded.
  always_comb begin
    rd_line = store[ar_idx];
`ifdef DRAM_CACHE_MEM_RESP_VALID_EN
    if (!line_vld[ar_idx]) rd_line = {{TAG_SIZE{1'b1}}, {DATA_WIDTH{1'b0}}};
`endif
    if (commit && (aw_idx == ar_idx)) rd_line = {aw_tag, w_data};
  end

  assign arready_o = (q_count < NW'(RQ_DEPTH));
  assign ar_fire   = arvalid_i && arready_o;

  mem_resp_queue #(
    .DEPTH  (RQ_DEPTH),
    .ID_W   (ID_WIDTH),
    .LINE_W (LINE_W),
    .LAT    (READ_LAT)
  ) u_rq (
    .clk       (clk),
    .rst       (rst),
    .push      (ar_fire),
    .push_id   (arid_i),
    .push_line (rd_line),
    .pop       (rvalid_o && rready_i),
    .head_id   (rid_o),
    .head_line (rdata_o),
    .head_ok   (rvalid_o),
    .count     (q_count)
  );
endmodule

// File: tb/tb_dram_cache_mem_resp.sv
// Directed bench for dram_cache_mem_resp: table of write/read vectors plus multi-cycle corner sequences.
module tb_dram_cache_mem_resp;
  localparam int LAT = 4;
  localparam int LW  = 528;

  logic         clk, rst;
  logic [3:0]   arid_i, rid_o, awid_i, wid_i;
  logic [31:0]  araddr_i, awaddr_i;
  logic         arvalid_i, arready_o, rvalid_o, rready_i;
  logic         awvalid_i, awready_o, wvalid_i, wready_o;
  logic [LW-1:0]  rdata_o;
  logic [511:0] wdata_i;

  dram_cache_mem_resp #(.READ_LAT(LAT), .RQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [3:0]   id;
    logic [511:0] data;
    logic [15:0]  tag;
  } vec_t;
  vec_t tv [4];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [511:0] d);
    awvalid_i = 1'b1; awaddr_i = a; wvalid_i = 1'b1; wdata_i = d;
    chk("wr_ready", LW'({awready_o, wready_o}), LW'(2'b11));
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
  endtask

  // Single read with rready held high: R must appear exactly LAT cycles after acceptance.
  task automatic do_read(input string nm, input logic [3:0] id, input logic [31:0] a,
                         input logic [LW-1:0] exp);
    rready_i = 1'b1;
    arvalid_i = 1'b1; arid_i = id; araddr_i = a;
    chk({nm, "_arready"}, LW'(arready_o), LW'(1'b1));
    tick();
    arvalid_i = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      chk({nm, "_early"}, LW'(rvalid_o), LW'(1'b0));
      tick();
    end
    chk({nm, "_rvalid"}, LW'(rvalid_o), LW'(1'b1));
    chk({nm, "_rid"}, LW'(rid_o), LW'(id));
    chk({nm, "_rdata"}, rdata_o, exp);
    tick();
    chk({nm, "_popped"}, LW'(rvalid_o), LW'(1'b0));
  endtask

  logic [LW-1:0] hold_data;
  logic [3:0]    hold_id;
  logic [3:0]    exp_ids [5];
  logic [LW-1:0] exp_lines [5];
  logic [511:0]  d2, d3;
  int            got_n;
  logic          seen_rv;

  initial begin
    tv[0] = '{32'h0001_2340, 4'd3, {16{32'hD1D1_0001}}, 16'h0001};
    tv[1] = '{32'hABCD_0000, 4'd7, {16{32'h1111_2222}}, 16'hABCD};
    tv[2] = '{32'h1234_FFC0, 4'd9, {16{32'hCAFE_F00D}}, 16'h1234};
    tv[3] = '{32'h0000_0047, 4'd1, {8{64'h0123_4567_89AB_CDEF}}, 16'h0000};
    d2 = {16{32'h2222_0002}};
    d3 = {16{32'h3333_0003}};

    rst = 1'b1;
    arid_i = '0; araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
    awid_i = '0; awaddr_i = '0; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_readies", LW'({arready_o, awready_o, wready_o}), LW'(3'b111));
    chk("rst_rvalid", LW'(rvalid_o), LW'(1'b0));
    chk("rst_rid", LW'(rid_o), LW'(4'd0));
    chk("rst_rdata", rdata_o, '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      do_write(tv[i].addr, tv[i].data);
      tick();
      do_read($sformatf("vec%0d", i), tv[i].id, tv[i].addr, {tv[i].tag, tv[i].data});
    end

    // Back-to-back reads, continuous rready: one R per cycle starting LAT after the first AR.
    rready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      arvalid_i = 1'b1; arid_i = 4'(i + 8); araddr_i = tv[i].addr;
      tick();
    end
    arvalid_i = 1'b0;
    for (int k = 4; k <= LAT + 3; k++) begin
      if (k >= LAT) begin
        chk("b2b_rvalid", LW'(rvalid_o), LW'(1'b1));
        chk("b2b_rid", LW'(rid_o), LW'(k - LAT + 8));
        chk("b2b_rdata", rdata_o, {tv[k-LAT].tag, tv[k-LAT].data});
      end
      tick();
    end
    chk("b2b_drained", LW'(rvalid_o), LW'(1'b0));

    // Backpressure: 4 accepts fill the queue, the 5th waits for the cycle after the first pop.
    rready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_ids[i] = 4'(i);
      exp_lines[i] = {tv[i%4].tag, tv[i%4].data};
    end
    for (int i = 0; i < 4; i++) begin
      arvalid_i = 1'b1; arid_i = 4'(i); araddr_i = tv[i].addr;
      chk("bp_accept", LW'(arready_o), LW'(1'b1));
      tick();
    end
    arid_i = 4'd4; araddr_i = tv[0].addr;
    chk("bp_full", LW'(arready_o), LW'(1'b0));
    chk("bp_head_valid", LW'(rvalid_o), LW'(1'b1));
    hold_id = rid_o; hold_data = rdata_o;
    chk("bp_head_id", LW'(rid_o), LW'(4'd0));
    tick();
    chk("bp_stable_id", LW'(rid_o), LW'(hold_id));
    chk("bp_stable_data", rdata_o, hold_data);
    chk("bp_head_data", rdata_o, exp_lines[0]);
    rready_i = 1'b1;
    chk("bp_no_pop_credit", LW'(arready_o), LW'(1'b0));
    tick();
    rready_i = 1'b0;
    chk("bp_ready_after_pop", LW'(arready_o), LW'(1'b1));
    tick();
    arvalid_i = 1'b0;
    got_n = 1;
    for (int c = 0; c < 40 && got_n < 5; c++) begin
      rready_i = (c % 2 == 1);
      if (rvalid_o && rready_i) begin
        chk("bp_order_id", LW'(rid_o), LW'(exp_ids[got_n]));
        chk("bp_order_data", rdata_o, exp_lines[got_n]);
        got_n++;
      end
      tick();
    end
    rready_i = 1'b0;
    chk("bp_drain_count", LW'(got_n), LW'(5));

    // Commit to index 0x08D in the same cycle an AR to 0x08D is accepted.
    awvalid_i = 1'b1; awaddr_i = 32'h0002_2340; wvalid_i = 1'b1; wdata_i = d2;
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    do_read("hazard", 4'd5, 32'h0005_2355, {16'h0002, d2});

    // AW without W holds for 10 cycles; no commit until W arrives.
    awvalid_i = 1'b1; awaddr_i = tv[1].addr;
    tick();
    awvalid_i = 1'b0;
    chk("uw_aw_blocked", LW'(awready_o), LW'(1'b0));
    chk("uw_w_open", LW'(wready_o), LW'(1'b1));
    do_read("uw_old", 4'd6, tv[1].addr, {tv[1].tag, tv[1].data});
    for (int c = 0; c < 10 - (LAT + 1); c++) tick();
    chk("uw_aw_still_blocked", LW'(awready_o), LW'(1'b0));
    wvalid_i = 1'b1; wdata_i = d3;
    chk("uw_w_ready", LW'(wready_o), LW'(1'b1));
    tick();
    wvalid_i = 1'b0;
    chk("uw_commit_readies", LW'({awready_o, wready_o}), LW'(2'b11));
    tick();
    chk("uw_aw_free", LW'(awready_o), LW'(1'b1));
    do_read("uw_new", 4'd2, tv[1].addr, {16'hABCD, d3});

    // Reset with two reads pending drops them.
    rready_i = 1'b0;
    for (int i = 2; i < 4; i++) begin
      arvalid_i = 1'b1; arid_i = 4'(i); araddr_i = tv[i].addr;
      tick();
    end
    arvalid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", LW'(rvalid_o), LW'(1'b0));
    chk("mid_rst_rid", LW'(rid_o), LW'(4'd0));
    @(negedge clk);
    rst = 1'b0;
    rready_i = 1'b1;
    seen_rv = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rvalid_o) seen_rv = 1'b1;
      tick();
    end
    chk("post_rst_no_r", LW'(seen_rv), LW'(1'b0));
    chk("post_rst_arready", LW'(arready_o), LW'(1'b1));

`ifdef DRAM_CACHE_MEM_RESP_VALID_EN
    do_read("inv_unwritten", 4'd7, 32'h5555_5500, {16'hFFFF, 512'd0});
    do_read("inv_after_rst", 4'd8, tv[2].addr, {16'hFFFF, 512'd0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
